// File: rtl/intr_ctrl.sv
// intr_ctrl: Wishbone-mapped interrupt controller.
// Synchronized sources, edge/level pending, mask, fixed-priority cause.
module intr_ctrl #(
  parameter int               N_SRC     = 6,
  parameter logic [N_SRC-1:0] EDGE_MASK = 6'b001000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_MASK  = 2'd1;
  localparam logic [1:0] A_CAUSE = 2'd2;
  localparam logic [1:0] A_CTRL  = 2'd3;

  logic [N_SRC-1:0] s1;
  logic [N_SRC-1:0] s2;
  logic [N_SRC-1:0] hist;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] pend_next;
  logic [1:0]       warm;
  logic             gen;
  logic             bus_go;
  logic             wr;
  logic [1:0]       sel;
  logic [31:0]      rd_data;
  logic [31:0]      cause_next;
  logic             unused_bits;

  assign sel    = ADDR[3:2];
  assign bus_go = STB & ~ACK;
  assign wr     = bus_go & WE;
  assign active = pending & mask;

  // Edges are ignored until the synchronizers hold post-reset samples.
  assign rise = (warm == 2'd3) ? (s2 & ~hist) : '0;

  assign clr = (wr && sel == A_PEND) ? DAT_I[N_SRC-1:0] : '0;

  // Edge bits: a new rise beats a same-cycle clear. Level bits follow s2.
  assign pend_next = (EDGE_MASK & ((pending & ~clr) | rise))
                   | (~EDGE_MASK & s2);

  assign unused_bits = ^{ADDR, DAT_I};

  // Register read mux, values as they stand before the bus edge.
  always_comb begin
    rd_data = '0;
    case (sel)
      A_PEND:  rd_data = 32'(pending);
      A_MASK:  rd_data = 32'(mask);
      A_CAUSE: rd_data = CAUSE;
      A_CTRL:  rd_data = {31'd0, gen};
      default: rd_data = '0;
    endcase
  end

  // Lowest-numbered active source wins.
  always_comb begin
    cause_next = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) cause_next = 32'(i);
    end
  end

  // Two-flop synchronizer, edge history and post-reset warm-up count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      hist <= '0;
      warm <= '0;
    end else begin
      s1   <= src;
      s2   <= s1;
      hist <= s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  // Pending state.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pend_next;
  end

  // Bus slave: one transaction per ACK, ACK drops on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask  <= '0;
      gen   <= 1'b0;
      ACK   <= 1'b0;
      DAT_O <= '0;
    end else if (bus_go) begin
      ACK   <= 1'b1;
      DAT_O <= rd_data;
      if (WE && sel == A_MASK) mask <= DAT_I[N_SRC-1:0];
      if (WE && sel == A_CTRL) gen  <= DAT_I[0];
    end else begin
      ACK <= 1'b0;
    end
  end

  // CPU request and cause, registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      INT   <= 1'b0;
      CAUSE <= '0;
    end else begin
      INT   <= gen & (|active);
      CAUSE <= cause_next;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed table, hand sequences and random traffic
// checked against a delay-line reference model of intr_ctrl.
module tb_intr_ctrl;

  localparam logic [5:0] EDGEM = 6'b001000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  src = '0;
  logic        STB = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] DAT_I = '0;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        INT;
  logic [31:0] CAUSE;

  int passed = 0;
  int total = 0;
  int nprint = 0;

  intr_ctrl #(.N_SRC(6), .EDGE_MASK(EDGEM)) dut (
    .clk(clk), .rst(rst), .src(src),
    .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK(ACK), .INT(INT), .CAUSE(CAUSE)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [5:0]  sq[$];
  int          e_cnt = 0;
  logic [5:0]  m_pend = '0;
  logic [5:0]  m_mask = '0;
  logic        m_gen = 1'b0;
  logic        m_ack = 1'b0;
  logic        m_int = 1'b0;
  logic [31:0] m_dato = '0;
  logic [31:0] m_cause = '0;

  task automatic model_step(input logic r, input logic [5:0] s,
                            input logic stb, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
    logic [5:0] op, om, act, d2, d3, clr;
    logic og;
    if (r) begin
      sq.delete();
      e_cnt = 0;
      m_pend = '0; m_mask = '0; m_gen = 1'b0;
      m_ack = 1'b0; m_int = 1'b0;
      m_dato = '0; m_cause = '0;
      return;
    end
    op = m_pend; om = m_mask; og = m_gen;
    sq.push_back(s);
    if (sq.size() > 4) void'(sq.pop_front());
    if (e_cnt < 10) e_cnt++;
    // src seen two and three edges back; pre-reset samples count as 0
    d2 = (e_cnt >= 3) ? sq[sq.size()-3] : '0;
    d3 = (e_cnt >= 4) ? sq[sq.size()-4] : '0;
    clr = '0;
    if (stb && !m_ack) begin
      case (a[3:2])
        2'd0: m_dato = {26'd0, op};
        2'd1: m_dato = {26'd0, om};
        2'd2: m_dato = m_cause;
        default: m_dato = {31'd0, og};
      endcase
      if (we) begin
        case (a[3:2])
          2'd0: clr = d[5:0];
          2'd1: m_mask = d[5:0];
          2'd3: m_gen = d[0];
          default: ;
        endcase
      end
      m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      if (EDGEM[i]) begin
        if (e_cnt >= 4 && d2[i] && !d3[i]) m_pend[i] = 1'b1;
        else if (clr[i]) m_pend[i] = 1'b0;
      end else begin
        m_pend[i] = d2[i];
      end
    end
    act = op & om;
    m_int = og && (act != 0);
    m_cause = 0;
    for (int i = 5; i >= 0; i--) if (act[i]) m_cause = i;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // One clock: capture inputs, step DUT and model, compare outputs.
  task automatic tick();
    logic r, stb, we;
    logic [5:0] s;
    logic [31:0] a, d;
    r = rst; s = src; stb = STB; we = WE; a = ADDR; d = DAT_I;
    @(posedge clk);
    #1;
    model_step(r, s, stb, we, a, d);
    total++;
    if (DAT_O === m_dato && ACK === m_ack && INT === m_int &&
        CAUSE === m_cause) begin
      passed++;
    end else if (nprint < 30) begin
      nprint++;
      $display("FAIL model t=%0t dat %h/%h ack %b/%b int %b/%b cause %0d/%0d",
               $time, DAT_O, m_dato, ACK, m_ack, INT, m_int, CAUSE, m_cause);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] dd, output logic [31:0] rd,
                     output logic i1, output logic i2);
    STB = 1'b1; WE = w; ADDR = a; DAT_I = dd;
    tick();
    chk("ack_rise", {31'd0, ACK}, 32'd1);
    rd = DAT_O; i1 = INT;
    STB = 1'b0; WE = 1'b0;
    tick();
    chk("ack_fall", {31'd0, ACK}, 32'd0);
    i2 = INT;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] rd;
    logic i1, i2;
    int b;

    tbl[0]  = '{1'b1, 32'h4,        32'hFFFF_FFFF, 32'h0};
    tbl[1]  = '{1'b0, 32'h4,        32'h0,         32'h3F};
    tbl[2]  = '{1'b1, 32'hC,        32'hFFFF_FFFF, 32'h0};
    tbl[3]  = '{1'b0, 32'hC,        32'h0,         32'h1};
    tbl[4]  = '{1'b1, 32'h8,        32'h5,         32'h0};
    tbl[5]  = '{1'b0, 32'h8,        32'h0,         32'h0};
    tbl[6]  = '{1'b1, 32'h0,        32'h3F,        32'h0};
    tbl[7]  = '{1'b0, 32'h0,        32'h0,         32'h0};
    tbl[8]  = '{1'b1, 32'hFFFF_FFF4, 32'h2A,       32'h3F};
    tbl[9]  = '{1'b0, 32'h14,       32'h0,         32'h2A};
    tbl[10] = '{1'b1, 32'hC,        32'h0,         32'h1};
    tbl[11] = '{1'b0, 32'hC,        32'h0,         32'h0};

    // reset state
    rst = 1'b1;
    tick();
    chk("rst_dato", DAT_O, 0);
    chk("rst_ack", {31'd0, ACK}, 0);
    chk("rst_int", {31'd0, INT}, 0);
    chk("rst_cause", CAUSE, 0);
    tick();
    rst = 1'b0;
    ticks(4);

    // register table
    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].data, rd, i1, i2);
      chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
    end

    // edge pulse on src[3]
    bus(1, 32'h4, 32'h3F, rd, i1, i2);
    bus(1, 32'hC, 32'h1, rd, i1, i2);
    src = 6'h08;
    tick();
    src = 6'h00;
    tick();
    STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
    tick();
    chk("edge_pend_k2", DAT_O, 0);
    chk("edge_int_k2", {31'd0, INT}, 0);
    STB = 1'b0;
    tick();
    chk("edge_int_k3", {31'd0, INT}, 1);
    chk("edge_cause_k3", CAUSE, 3);
    ticks(3);
    chk("edge_int_hold", {31'd0, INT}, 1);
    bus(0, 32'h0, 0, rd, i1, i2);
    chk("edge_pend_rd", rd, 32'h08);

    // W1C clear
    bus(1, 32'h0, 32'h08, rd, i1, i2);
    chk("w1c_rd", rd, 32'h08);
    chk("w1c_int_w", {31'd0, i1}, 1);
    chk("w1c_int_w1", {31'd0, i2}, 0);
    bus(0, 32'h0, 0, rd, i1, i2);
    chk("w1c_pend_rd", rd, 0);

    // clear and new rise on the same edge: set wins
    src = 6'h08;
    tick();
    tick();
    STB = 1'b1; WE = 1'b1; ADDR = 32'h0; DAT_I = 32'h08;
    tick();
    STB = 1'b0; WE = 1'b0; src = 6'h00;
    tick();
    chk("race_int", {31'd0, INT}, 1);
    bus(0, 32'h0, 0, rd, i1, i2);
    chk("race_pend", rd, 32'h08);
    bus(1, 32'h0, 32'h08, rd, i1, i2);

    // level sources and mask priority
    bus(1, 32'h4, 32'h12, rd, i1, i2);
    src = 6'h12;
    ticks(4);
    chk("lvl_cause", CAUSE, 1);
    chk("lvl_int", {31'd0, INT}, 1);
    bus(1, 32'h4, 32'h10, rd, i1, i2);
    chk("lvl_int_w1", {31'd0, i2}, 1);
    chk("lvl_cause4", CAUSE, 4);
    bus(1, 32'h4, 32'h00, rd, i1, i2);
    chk("unmask_int_w", {31'd0, i1}, 1);
    chk("unmask_int_w1", {31'd0, i2}, 0);
    src = 6'h00;

    // GEN=0 polling, then enable
    bus(1, 32'hC, 32'h0, rd, i1, i2);
    src = 6'h11;
    bus(1, 32'h4, 32'h10, rd, i1, i2);
    ticks(3);
    chk("nogen_int", {31'd0, INT}, 0);
    chk("nogen_cause", CAUSE, 4);
    bus(1, 32'h4, 32'h01, rd, i1, i2);
    bus(0, 32'h8, 0, rd, i1, i2);
    chk("nogen_cause_rd", rd, 0);
    bus(1, 32'hC, 32'h1, rd, i1, i2);
    chk("gen_int_w", {31'd0, i1}, 0);
    chk("gen_int_w1", {31'd0, i2}, 1);

    // reset mid-transaction with STB held; src[3] high across release
    src = 6'h09;
    ticks(3);
    STB = 1'b1; WE = 1'b0; ADDR = 32'hC;
    tick();
    chk("abort_ack", {31'd0, ACK}, 1);
    chk("abort_dato", DAT_O, 1);
    rst = 1'b1;
    tick();
    chk("abort_rst_dato", DAT_O, 0);
    chk("abort_rst_ack", {31'd0, ACK}, 0);
    chk("abort_rst_int", {31'd0, INT}, 0);
    chk("abort_rst_cause", CAUSE, 0);
    rst = 1'b0;
    tick();
    chk("rel_ack1", {31'd0, ACK}, 1);
    tick();
    chk("rel_ack2", {31'd0, ACK}, 0);
    tick();
    chk("rel_ack3", {31'd0, ACK}, 1);
    STB = 1'b0;
    ticks(4);
    bus(0, 32'h0, 0, rd, i1, i2);
    chk("rel_no_edge", rd, 32'h01);
    src = 6'h00;

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 5);
        src[b] = ~src[b];
      end
      rst = ($urandom_range(0, 149) == 0);
      STB = $urandom_range(0, 1);
      WE = $urandom_range(0, 1);
      ADDR = $urandom;
      DAT_I = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
      tick();
    end
    rst = 1'b0; STB = 1'b0; WE = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
